// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: drives program-memory word addresses, tracks the
// single in-flight read and buffers returned words in a skid FIFO for decode.
module fetch_pc_unit #(
  parameter int            AW       = 10,
  parameter int            DW       = 32,
  parameter int            DEPTH    = 2,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          Reset,
  output logic [AW-1:0] Address,
  output logic          Fetch_En,
  input  logic [DW-1:0] Instruction,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_addr,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [DW-1:0] instr_out,
  output logic [AW-1:0] instr_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0] fetch_pc_reg, fetch_pc_next;
  logic          inflight_reg;
  logic [AW-1:0] inflight_pc_reg;
  logic          squash_reg;
  logic [CW-1:0] count_reg;
  logic [PW-1:0] rd_ptr_reg, wr_ptr_reg;

  logic [DW-1:0] data_mem [DEPTH];
  logic [AW-1:0] pc_mem   [DEPTH];

  logic          pop, push, issue;
  logic [CW:0]   credits_used;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign instr_valid  = (count_reg != '0);
  assign pop          = instr_valid & instr_ready;
  // Slots already committed: buffered words plus the read on its way back,
  // minus the one decode takes this cycle.
  assign credits_used = {1'b0, count_reg} + (CW+1)'(inflight_reg) - (CW+1)'(pop);
  assign issue        = !redirect_valid && (credits_used < (CW+1)'(DEPTH));
  // A word returning during a redirect, or the cycle after one, belongs to the old path.
  assign push         = inflight_reg & !squash_reg & !redirect_valid;

  assign Address  = fetch_pc_reg;
  assign Fetch_En = issue & !Reset;

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    if (redirect_valid)
      fetch_pc_next = redirect_addr;
    else if (issue)
      fetch_pc_next = fetch_pc_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      fetch_pc_reg    <= RESET_PC;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= '0;
      squash_reg      <= 1'b0;
      count_reg       <= '0;
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      inflight_reg <= issue;
      squash_reg   <= redirect_valid;
      if (issue)
        inflight_pc_reg <= fetch_pc_reg;
      if (redirect_valid) begin
        count_reg  <= '0;
        rd_ptr_reg <= '0;
        wr_ptr_reg <= '0;
      end else begin
        if (push)
          wr_ptr_reg <= ptr_inc(wr_ptr_reg);
        if (pop)
          rd_ptr_reg <= ptr_inc(rd_ptr_reg);
        count_reg <= count_reg + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!Reset && push) begin
      data_mem[wr_ptr_reg] <= Instruction;
      pc_mem[wr_ptr_reg]   <= inflight_pc_reg;
    end
  end

  // Head is forced to zero when empty so stale entries never leak out.
  assign instr_out = instr_valid ? data_mem[rd_ptr_reg] : '0;
  assign instr_pc  = instr_valid ? pc_mem[rd_ptr_reg]   : '0;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: registered program-memory model, negedge scoreboard of
// expected PCs, plus directed checks on address, enable and handshake timing.
module tb_fetch_pc_unit;

  logic        clk;
  logic        Reset;
  logic [9:0]  Address;
  logic        Fetch_En;
  logic [31:0] Instruction;
  logic        redirect_valid;
  logic [9:0]  redirect_addr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [9:0]  instr_pc;

  int checks = 0;
  int errors = 0;
  logic [9:0]  exp_q [$];
  logic [31:0] held_word;

  fetch_pc_unit #(.AW(10), .DW(32), .DEPTH(2), .RESET_PC(10'h000)) dut (
    .clk            (clk),
    .Reset          (Reset),
    .Address        (Address),
    .Fetch_En       (Fetch_En),
    .Instruction    (Instruction),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_out      (instr_out),
    .instr_pc       (instr_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [9:0] a);
    return {22'b0, a} * 32'h1111_1111;
  endfunction

  // Program memory with a one-cycle registered read.
  always @(posedge clk) Instruction <= mem_word(Address);

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load_stream(input logic [9:0] start);
    logic [9:0] a;
    exp_q.delete();
    a = start;
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back(a);
      a = a + 10'd1;
    end
  endtask

  // Scoreboard: every accepted word must be the next expected PC and its memory word.
  always @(negedge clk) begin
    if (Reset) begin
      load_stream(10'h000);
    end else begin
      if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          check_val("sb_underflow", {22'b0, instr_pc}, 32'hFFFF_FFFF);
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          $display("pop pc=%03h instr=%08h expected pc=%03h", instr_pc, instr_out, e);
          check_val("sb_pc", {22'b0, instr_pc}, {22'b0, e});
          check_val("sb_instr", instr_out, mem_word(e));
        end
      end
      if (redirect_valid)
        load_stream(redirect_addr);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    Reset = 1'b1;
    instr_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_addr = '0;

    step(); #1;
    check_val("rst_valid", {31'b0, instr_valid}, 32'd0);
    check_val("rst_fetch_en", {31'b0, Fetch_En}, 32'd0);
    check_val("rst_address", {22'b0, Address}, 32'd0);
    check_val("rst_instr_out", instr_out, 32'd0);
    check_val("rst_instr_pc", {22'b0, instr_pc}, 32'd0);

    // Power-up stream: cycles 0..3
    step(); Reset = 1'b0; #1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin step(); #1; end
      check_val("t1_address", {22'b0, Address}, k);
      check_val("t1_fetch_en", {31'b0, Fetch_En}, 32'd1);
      check_val("t1_valid", {31'b0, instr_valid}, (k >= 2) ? 32'd1 : 32'd0);
    end

    // Stall three cycles with pc 2 at the head
    step(); instr_ready = 1'b0; #1;
    check_val("t2_head_pc", {22'b0, instr_pc}, 32'h2);
    check_val("t2_fetch_en_c4", {31'b0, Fetch_En}, 32'd0);
    held_word = mem_word(10'h2);
    for (int k = 0; k < 2; k++) begin
      step(); #1;
      check_val("t2_hold_instr", instr_out, held_word);
      check_val("t2_hold_pc", {22'b0, instr_pc}, 32'h2);
      check_val("t2_hold_valid", {31'b0, instr_valid}, 32'd1);
      check_val("t2_fetch_en_stall", {31'b0, Fetch_En}, 32'd0);
    end
    step(); instr_ready = 1'b1; #1;
    check_val("t2_resume_fetch_en", {31'b0, Fetch_En}, 32'd1);
    check_val("t2_resume_address", {22'b0, Address}, 32'h4);
    step(); #1;
    check_val("t2_next_pc", {22'b0, instr_pc}, 32'h3);

    // Redirect to 0x100 while pc 5 is in flight (cycle 9)
    step(); redirect_valid = 1'b1; redirect_addr = 10'h100; #1;
    check_val("t3_head_pc", {22'b0, instr_pc}, 32'h4);
    check_val("t3_fetch_en_redir", {31'b0, Fetch_En}, 32'd0);
    step(); redirect_valid = 1'b0; #1;
    check_val("t3_flush_valid", {31'b0, instr_valid}, 32'd0);
    check_val("t3_address", {22'b0, Address}, 32'h100);
    check_val("t3_fetch_en", {31'b0, Fetch_En}, 32'd1);
    step(); #1;
    check_val("t3_valid_r2", {31'b0, instr_valid}, 32'd0);
    step(); #1;
    check_val("t3_valid_r3", {31'b0, instr_valid}, 32'd1);
    check_val("t3_pc_r3", {22'b0, instr_pc}, 32'h100);

    // Redirect near the top of the address space to exercise wrap
    step(); redirect_valid = 1'b1; redirect_addr = 10'h3FE; #1;
    step(); redirect_valid = 1'b0; #1;
    check_val("t4_address", {22'b0, Address}, 32'h3FE);
    step();
    step(); #1;
    check_val("t4_address_wrap", {22'b0, Address}, 32'h000);
    check_val("t4_pc_3fe", {22'b0, instr_pc}, 32'h3FE);
    step();
    step(); #1;
    check_val("t4_pc_wrap", {22'b0, instr_pc}, 32'h000);
    step();

    // Redirect with a pop in the same cycle, then a second redirect straight after
    step(); redirect_valid = 1'b1; redirect_addr = 10'h040; #1;
    check_val("t5_pop_valid", {31'b0, instr_valid}, 32'd1);
    check_val("t5_pop_pc", {22'b0, instr_pc}, 32'h002);
    step(); redirect_addr = 10'h080; #1;
    check_val("t5_address_040", {22'b0, Address}, 32'h040);
    check_val("t5_fetch_en_blocked", {31'b0, Fetch_En}, 32'd0);
    check_val("t5_flush_valid", {31'b0, instr_valid}, 32'd0);
    step(); redirect_valid = 1'b0; #1;
    check_val("t5_address_080", {22'b0, Address}, 32'h080);
    check_val("t5_fetch_en", {31'b0, Fetch_En}, 32'd1);
    step();
    step(); #1;
    check_val("t5_pc_080", {22'b0, instr_pc}, 32'h080);

    // Fill the FIFO with a stall, then reset mid-stream
    step(); instr_ready = 1'b0; #1;
    check_val("t6_head_pc", {22'b0, instr_pc}, 32'h081);
    step();
    step(); #1;
    check_val("t6_full_valid", {31'b0, instr_valid}, 32'd1);
    check_val("t6_full_fetch_en", {31'b0, Fetch_En}, 32'd0);
    step(); Reset = 1'b1; instr_ready = 1'b1; #1;
    check_val("t6_rst_fetch_en", {31'b0, Fetch_En}, 32'd0);
    step(); Reset = 1'b0; #1;
    check_val("t6_valid", {31'b0, instr_valid}, 32'd0);
    check_val("t6_address", {22'b0, Address}, 32'd0);
    check_val("t6_fetch_en", {31'b0, Fetch_En}, 32'd1);
    for (int k = 1; k < 6; k++) begin
      step(); #1;
      check_val("t6_restart_address", {22'b0, Address}, k);
      check_val("t6_restart_valid", {31'b0, instr_valid}, (k >= 2) ? 32'd1 : 32'd0);
    end
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
